alu_issue_unit: RTL

Registered issue/capture stage that drives the RISC-V single-cycle ALU port (control code, operand A, operand B) and collects its result and zero flag. It accepts decoded instruction fields from decode over a valid/ready handshake, translates opcode/funct fields into the 4-bit ALU control code, and selects operands. It returns a write-back record (rd, result, branch decision) over a second valid/ready handshake. It sits between decode and write-back, and is the producing side of the ALU interface.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_ctl_decode.sv | 75 +++++++
 rtl/alu_issue_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode constants and issue-stage metadata.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_SUB = 4'd6,
      ALU_SLT = 4'd7,
      ALU_NOR = 4'd12
   } alu_ctl_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [4:0] rd;
      logic       is_branch;
      logic       br_sense;   // 1: taken on zero (BEQ), 0: taken on non-zero (BNE)
      logic       illegal;
   } issue_meta_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Opcode/funct decode into ALU control code, operand-B select and branch/illegal flags.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module alu_ctl_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] ctl,
   output logic       b_imm,
   output logic       is_branch,
   output logic       br_sense,
   output logic       rd_zero,
   output logic       illegal
);

   always_comb begin
      ctl       = ALU_ADD;
      b_imm     = 1'b0;
      is_branch = 1'b0;
      br_sense  = 1'b0;
      rd_zero   = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP_R: begin
            case (funct3)
               3'b000:  ctl = funct7_5 ? ALU_SUB : ALU_ADD;
               3'b111:  ctl = ALU_AND;
               3'b110:  ctl = ALU_OR;
               3'b010:  ctl = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_IMM: begin
            b_imm = 1'b1;
            case (funct3)
               3'b000:  ctl = ALU_ADD;
               3'b111:  ctl = ALU_AND;
               3'b110:  ctl = ALU_OR;
               3'b010:  ctl = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_LOAD: b_imm = 1'b1;
         OP_STORE: begin
            b_imm   = 1'b1;
            rd_zero = 1'b1;
         end
         OP_BRANCH: begin
            ctl     = ALU_SUB;
            rd_zero = 1'b1;
            case (funct3)
               3'b000: begin
                  is_branch = 1'b1;
                  br_sense  = 1'b1;
               end
               3'b001:  is_branch = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase

      // Illegal records travel as a harmless ADD of zeros with no side effects.
      if (illegal) begin
         ctl       = ALU_ADD;
         b_imm     = 1'b0;
         is_branch = 1'b0;
         br_sense  = 1'b0;
         rd_zero   = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage driving the external ALU port and capturing its result into a write-back record.
// Latency: ALU ports valid one edge after acceptance, out_valid one edge later.
// Backpressure: out_ready low stalls W, then I; in_ready drops only when both stages are held.
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   output logic [3:0]      alu_ctl,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_zero,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_result,
   output logic            out_br_taken,
   output logic            out_illegal
);

   logic        i_v;
   logic        w_v;
   issue_meta_t i_meta;
   issue_meta_t d_meta;

   logic [3:0]  d_ctl;
   logic        d_b_imm;
   logic        d_is_branch;
   logic        d_br_sense;
   logic        d_rd_zero;
   logic        d_illegal;

   logic        accept;
   logic        advance;

   alu_ctl_decode u_decode (
      .opcode    (in_opcode),
      .funct3    (in_funct3),
      .funct7_5  (in_funct7_5),
      .ctl       (d_ctl),
      .b_imm     (d_b_imm),
      .is_branch (d_is_branch),
      .br_sense  (d_br_sense),
      .rd_zero   (d_rd_zero),
      .illegal   (d_illegal)
   );

   assign in_ready  = !i_v || !w_v || out_ready;
   assign accept    = in_valid && in_ready;
   assign advance   = i_v && (!w_v || out_ready);
   assign out_valid = w_v;

   always_comb begin
      d_meta           = '0;
      d_meta.rd        = d_rd_zero ? 5'd0 : in_rd;
      d_meta.is_branch = d_is_branch;
      d_meta.br_sense  = d_br_sense;
      d_meta.illegal   = d_illegal;
   end

   // W samples alu_out from the operands currently held in I while I is overwritten
   // at the same edge, so back-to-back instructions always capture their own result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         i_v          <= 1'b0;
         w_v          <= 1'b0;
         alu_ctl      <= 4'd0;
         alu_a        <= '0;
         alu_b        <= '0;
         i_meta       <= '0;
         out_rd       <= 5'd0;
         out_result   <= '0;
         out_br_taken <= 1'b0;
         out_illegal  <= 1'b0;
      end else begin
         if (accept) begin
            i_v     <= 1'b1;
            alu_ctl <= d_ctl;
            alu_a   <= d_illegal ? '0 : in_rs1_val;
            alu_b   <= d_illegal ? '0 : (d_b_imm ? in_imm : in_rs2_val);
            i_meta  <= d_meta;
         end else if (advance) begin
            i_v <= 1'b0;
         end

         if (advance) begin
            w_v          <= 1'b1;
            out_rd       <= i_meta.rd;
            out_result   <= i_meta.illegal ? '0 : alu_out;
            out_br_taken <= i_meta.is_branch && (alu_zero == i_meta.br_sense);
            out_illegal  <= i_meta.illegal;
         end else if (out_ready) begin
            w_v <= 1'b0;
         end
      end
   end

endmodule
